// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: synchronizes and debounces the padframe power-good,
// then releases NUM_DOMAINS active-low domain resets one at a time in a fixed order.
module por_reset_sequencer #(
    parameter int NUM_DOMAINS     = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int SWRST_HOLD      = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   por_good,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_n,
    output logic                   seq_done,
    output logic [1:0]             state
);

    localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > STAGGER_CYCLES) ? DEBOUNCE_CYCLES : STAGGER_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > SWRST_HOLD) ? CNT_MAX_A : SWRST_HOLD;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int IW        = $clog2(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] STG_LAST  = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(SWRST_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SWRST   = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pg_s;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   seq_done_q, seq_done_d;

    // Power-good synchronizer; only the last stage is used downstream.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], por_good};
        end
    end

    assign pg_s = sync_q[SYNC_STAGES-1];

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_HOLD;
            cnt_q      <= {CW{1'b0}};
            idx_q      <= {IW{1'b0}};
            rst_n_q    <= {NUM_DOMAINS{1'b0}};
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_n_q    <= rst_n_d;
            seq_done_q <= seq_done_d;
        end
    end

    // Next-state and next-output logic; loss of power-good beats every other event.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_n_d    = rst_n_q;
        seq_done_d = seq_done_q;

        case (state_q)
            ST_HOLD: begin
                rst_n_d    = {NUM_DOMAINS{1'b0}};
                seq_done_d = 1'b0;
                idx_d      = {IW{1'b0}};
                if (!pg_s) begin
                    cnt_d = {CW{1'b0}};
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RELEASE: begin
                if (!pg_s) begin
                    state_d    = ST_HOLD;
                    rst_n_d    = {NUM_DOMAINS{1'b0}};
                    seq_done_d = 1'b0;
                    cnt_d      = {CW{1'b0}};
                    idx_d      = {IW{1'b0}};
                end else if (cnt_q == STG_LAST) begin
                    // Earlier bits keep their released value from rst_n_q.
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IW'(i)) begin
                            rst_n_d[i] = 1'b1;
                        end else begin
                            rst_n_d[i] = rst_n_q[i];
                        end
                    end
                    idx_d = idx_q + IW'(1);
                    cnt_d = {CW{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_RUN;
                        seq_done_d = 1'b1;
                    end else begin
                        seq_done_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RUN: begin
                rst_n_d    = {NUM_DOMAINS{1'b1}};
                seq_done_d = 1'b1;
                if (!pg_s) begin
                    state_d    = ST_HOLD;
                    rst_n_d    = {NUM_DOMAINS{1'b0}};
                    seq_done_d = 1'b0;
                    cnt_d      = {CW{1'b0}};
                    idx_d      = {IW{1'b0}};
                end else if (sw_rst_req) begin
                    state_d    = ST_SWRST;
                    rst_n_d    = {NUM_DOMAINS{1'b0}};
                    seq_done_d = 1'b0;
                    cnt_d      = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_SWRST: begin
                rst_n_d    = {NUM_DOMAINS{1'b0}};
                seq_done_d = 1'b0;
                if (!pg_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = {CW{1'b0}};
                    idx_d   = {IW{1'b0}};
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = {CW{1'b0}};
                    idx_d   = {IW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d    = ST_HOLD;
                rst_n_d    = {NUM_DOMAINS{1'b0}};
                seq_done_d = 1'b0;
                cnt_d      = {CW{1'b0}};
                idx_d      = {IW{1'b0}};
            end
        endcase
    end

    assign rst_n    = rst_n_q;
    assign seq_done = seq_done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Self-checking bench for por_reset_sequencer: expected release edges are queued
// when stimulus is applied and matched against observed rising edges of rst_n/seq_done.
module tb_por_reset_sequencer;

    localparam int ND = 3;

    typedef struct {
        int bit_idx;
        int edge_no;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          por_good = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic [ND-1:0] rst_n;
    logic          seq_done;
    logic [1:0]    state;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [ND:0] prev_obs = '0;

    por_reset_sequencer #(
        .NUM_DOMAINS(ND), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16),
        .STAGGER_CYCLES(8), .SWRST_HOLD(4)
    ) dut (
        .clk(clk), .resetn(resetn), .por_good(por_good), .sw_rst_req(sw_rst_req),
        .rst_n(rst_n), .seq_done(seq_done), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every rising edge of a domain reset or seq_done must match the head of the scoreboard.
    task automatic monitor_edges();
        logic [ND:0] cur;
        exp_t e;
        cur = {seq_done, rst_n};
        for (int b = 0; b <= ND; b++) begin
            if (cur[b] === 1'b1 && prev_obs[b] !== 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rise: bit %0d rose at edge %0d, none expected", b, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (e.bit_idx !== b || e.edge_no !== cyc) begin
                        errors++;
                        $display("FAIL rise_timing: bit %0d at edge %0d, expected bit %0d at edge %0d",
                                 b, cyc, e.bit_idx, e.edge_no);
                    end
                end
            end
        end
        prev_obs = cur;
    endtask

    always @(negedge clk) monitor_edges();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int edge_no);
        exp_t e;
        e.bit_idx = b;
        e.edge_no = edge_no;
        sb_q.push_back(e);
    endtask

    task automatic push_full(input int t0);
        push(0, t0 + 26);
        push(1, t0 + 34);
        push(2, t0 + 42);
        push(ND, t0 + 42);
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected releases never seen, expected 0 pending", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {rst_n, seq_done, state}, 6'b000000);
        end
        repeat (3) step();
        resetn = 1'b1;
    endtask

    task automatic test_powerup();
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL powerup_hold: cycle %0d got %b expected %b", i, {rst_n, seq_done, state}, 6'b000000);
            end
        end
    endtask

    task automatic test_clean_sequence();
        int t0;
        step();
        t0 = cyc;
        por_good = 1'b1;
        push_full(t0);
        repeat (45) step();
        check_sb_empty("clean_releases");
        checks++;
        if ({rst_n, seq_done, state} !== {3'b111, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL clean_run: got %b expected %b", {rst_n, seq_done, state}, 6'b111110);
        end
    endtask

    task automatic test_glitch();
        int t0;
        step();
        por_good = 1'b0;
        repeat (5) step();
        checks++;
        if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL glitch_prehold: got %b expected %b", {rst_n, seq_done, state}, 6'b000000);
        end
        por_good = 1'b1;
        repeat (10) step();
        por_good = 1'b0;
        step();
        t0 = cyc;
        por_good = 1'b1;
        push_full(t0);
        repeat (45) step();
        check_sb_empty("glitch_releases");
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL glitch_run: state %0d expected 2", state);
        end
    endtask

    task automatic test_sw_reset();
        int e;
        step();
        sw_rst_req = 1'b1;
        step();
        e = cyc;
        sw_rst_req = 1'b0;
        push(0, e + 12);
        push(1, e + 20);
        push(2, e + 28);
        push(ND, e + 28);
        checks++;
        if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL swrst_entry: got %b expected %b", {rst_n, seq_done, state}, 6'b000011);
        end
        for (int k = 1; k <= 4; k++) begin
            if (k == 1) sw_rst_req = 1'b1;
            step();
            sw_rst_req = 1'b0;
            checks++;
            if (state !== ((k < 4) ? 2'd3 : 2'd1)) begin
                errors++;
                $display("FAIL swrst_state: edge e+%0d state %0d expected %0d", k, state, (k < 4) ? 3 : 1);
            end
        end
        repeat (26) step();
        check_sb_empty("swrst_releases");
        checks++;
        if ({rst_n, seq_done, state} !== {3'b111, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL swrst_run: got %b expected %b", {rst_n, seq_done, state}, 6'b111110);
        end
    endtask

    task automatic test_brownout();
        int t0;
        step();
        por_good = 1'b0;
        repeat (5) step();
        t0 = cyc;
        por_good = 1'b1;
        push(0, t0 + 26);
        repeat (28) step();
        checks++;
        if ({rst_n, state} !== {3'b001, 2'd1}) begin
            errors++;
            $display("FAIL brownout_partial: got %b expected %b", {rst_n, state}, 5'b00101);
        end
        por_good = 1'b0;
        repeat (3) step();
        checks++;
        if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL brownout_hold: got %b expected %b", {rst_n, seq_done, state}, 6'b000000);
        end
        check_sb_empty("brownout_partial_releases");
        repeat (3) step();
        t0 = cyc;
        por_good = 1'b1;
        push_full(t0);
        repeat (45) step();
        check_sb_empty("brownout_restart_releases");
        checks++;
        if ({rst_n, seq_done, state} !== {3'b111, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL brownout_run: got %b expected %b", {rst_n, seq_done, state}, 6'b111110);
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        step();
        por_good = 1'b0;
        repeat (2) step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        checks++;
        if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL simul_priority: got %b expected %b", {rst_n, seq_done, state}, 6'b000000);
        end
        repeat (2) step();
        t0 = cyc;
        por_good = 1'b1;
        push(0, t0 + 26);
        repeat (30) step();
        checks++;
        if ({rst_n, state} !== {3'b001, 2'd1}) begin
            errors++;
            $display("FAIL simul_release: got %b expected %b", {rst_n, state}, 5'b00101);
        end
        #2;
        resetn = 1'b0;
        por_good = 1'b0;
        #1;
        checks++;
        if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", {rst_n, seq_done, state}, 6'b000000);
        end
        check_sb_empty("simul_releases");
        repeat (3) step();
        resetn = 1'b1;
        repeat (3) step();
        checks++;
        if ({rst_n, seq_done, state} !== {3'b000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL post_reset_hold: got %b expected %b", {rst_n, seq_done, state}, 6'b000000);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_clean_sequence();
        test_glitch();
        test_sw_reset();
        test_brownout();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/por_reset_sequencer.md
Name: por_reset_sequencer

Overview:
- Sequences reset release for the 3.3V core after power-on.
- Takes the level-shifted, asynchronous power-good signal from the padframe POR level-shift buffer and synchronizes and debounces it.
- Releases NUM_DOMAINS active-low reset outputs one at a time, staggered, so SRAM macros, test logic and the bus interface come up in a fixed order.
- Also provides a software-requested re-sequence. It sits in the 3.3V core domain, next to the padframe POR output.

Parameters:
- NUM_DOMAINS, 3: number of staged reset outputs; legal range 1..8.
- SYNC_STAGES, 2: synchronizer flops on por_good; minimum 2.
- DEBOUNCE_CYCLES, 16: consecutive synchronized-high cycles required before release starts; minimum 1.
- STAGGER_CYCLES, 8: cycles between successive domain releases, and before the first one; minimum 1.
- SWRST_HOLD, 4: cycles all domains are held in reset after a software request; minimum 1.

Ports:
- clk, input, 1: core clock.
- resetn, input, 1: asynchronous active-low reset for all state in this block.
- por_good, input, 1: level-shifted power-good, asynchronous to clk; 1 = power good.
- sw_rst_req, input, 1: single-cycle software re-sequence request, synchronous to clk.
- rst_n, output, NUM_DOMAINS: active-low domain resets; bit 0 is released first.
- seq_done, output, 1: 1 when all domains are released and the block is in RUN.
- state, output, 2: current FSM state, for debug readback.

Behaviour:
- Async reset (resetn=0): synchronizer=0, counters=0, domain index=0, state=HOLD(0), rst_n=all 0, seq_done=0. All outputs are registered.
- pg_s: por_good after SYNC_STAGES flops; all later logic uses pg_s only.
- Counter widths: sized to the largest of DEBOUNCE_CYCLES, STAGGER_CYCLES and SWRST_HOLD. Domain index width is clog2(NUM_DOMAINS+1).
- HOLD (0):
  - rst_n=0, seq_done=0.
  - pg_s=0 clears cnt.
  - pg_s=1 increments cnt.
  - When pg_s=1 and cnt==DEBOUNCE_CYCLES-1: go to RELEASE with cnt=0, idx=0.
- RELEASE (1):
  - cnt increments every cycle.
  - When cnt==STAGGER_CYCLES-1: rst_n[idx]<=1, idx++, cnt<=0.
  - When the last domain is released: go to RUN and set seq_done<=1 on the same edge.
  - Bits already released stay released.
- RUN (2):
  - rst_n=all 1, seq_done=1.
  - sw_rst_req=1: go to SWRST; on the same edge rst_n<=0, seq_done<=0, cnt<=0.
- SWRST (3):
  - cnt increments.
  - When cnt==SWRST_HOLD-1: go to RELEASE with cnt=0, idx=0. There is no debounce on this path.
- Priority: pg_s=0 in RELEASE, RUN or SWRST forces HOLD on the next edge, with rst_n<=0, seq_done<=0, cnt<=0, idx<=0. This overrides sw_rst_req and any stagger or hold event in the same cycle.
- sw_rst_req is ignored in HOLD, RELEASE and SWRST; it is not queued.
- No glitches on rst_n: each bit is driven directly from a flop.
- Latency from a clean por_good rise to rst_n[k] rising is SYNC_STAGES + DEBOUNCE_CYCLES + (k+1)*STAGGER_CYCLES edges, with ±1 for asynchronous sampling.

Test Plan (default parameters):
- Power-up: resetn released, por_good held 0 for 50 cycles -> rst_n=000, state=0, seq_done=0 throughout.
- Clean sequence: por_good rises at edge 0 -> rst_n[0] rises at edge 26 (±1), rst_n[1] at 34, rst_n[2] at 42, seq_done=1 at 42, state=2.
- Glitch: por_good high 10 cycles, low 1 cycle, then high -> cnt restarts; rst_n[0] rises 26 (±1) edges after the final rise, not earlier.
- SW reset: sw_rst_req pulsed in RUN and sampled at edge e -> rst_n=000 and seq_done=0 at e, state=3 for 4 cycles, rst_n[0] at e+12, rst_n[2] at e+28, seq_done=1 at e+28. A second pulse during SWRST has no effect.
- Brown-out mid-sequence: por_good drops after rst_n[0] is released -> rst_n=000 and state=0 within 3 edges. The sequence restarts with the full 26/34/42 timing once por_good returns.
- Simultaneous events: sw_rst_req and pg_s falling on the same RUN cycle -> state=HOLD (not SWRST), rst_n=000; resetn asserted mid-RELEASE -> all outputs 0 immediately, without waiting for a clock edge.
